mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Job-level sequencer for the 4x4-bit multiply-accumulate datapath. It accepts a dot-product job of length `len`, clears the accumulator, and streams `len` operand pairs through the MAC under a valid/ready handshake. It then presents the final accumulation with a result handshake. It sits between an operand source (memory reader or host FIFO) and the consumer of `mac_out`, replacing free-running accumulation with framed, countable jobs.

## Interface
- `DW`, default 4: operand width (`a`, `b`).
- `AW`, default 8: accumulator and result width; must satisfy AW ≥ 2·DW.
- `LW`, default 4: job-length field width; maximum job is 2^LW−1 beats.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `start`, input, 1: job request; sampled only in IDLE.
- `len`, input, LW: number of operand pairs; latched when `start` is accepted.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `in_valid`, input, 1: operand pair present.
- `in_ready`, output, 1: controller accepts a pair this cycle.
- `a`, input, DW: unsigned operand.
- `b`, input, DW: unsigned operand.
- `out_valid`, output, 1: `mac_out` holds the final job result.
- `out_ready`, input, 1: consumer takes the result.
- `mac_out`, output, AW: accumulator value.
- `ovf`, output, 1: sticky flag; at least one carry out of AW bits occurred during this job.

## Operation
- States and transitions:
  - IDLE → CLR on `start`.
  - CLR → RUN after one cycle.
  - RUN → DONE on acceptance of the last beat.
  - DONE → IDLE on `out_ready`.
  - IDLE → DONE directly on `start` with `len`==0. The accumulator is cleared in that same edge, so the result is 0 and `ovf` is 0.
- IDLE:
  - `in_ready`=0 and `out_valid`=0.
  - `mac_out` holds the previous job's result.
  - `start` latches `len` into `len_q` and zeroes the beat counter.
- CLR: accumulator ← 0, `ovf` ← 0, `in_ready`=0.
- RUN:
  - `in_ready`=1.
  - A beat is accepted when `in_valid` and `in_ready` are both high.
  - On an accepted beat: acc ← (acc + a·b) mod 2^AW; `ovf` ← `ovf` | carry; counter++.
  - A cycle with `in_valid`=0 leaves acc and the counter unchanged.
  - The beat accepted when counter == `len_q`−1 is the last; the next state is DONE.
- DONE:
  - `out_valid`=1; `mac_out` and `ovf` are held stable until `out_ready`=1.
  - `in_ready`=0; operands offered in this state are not consumed.
- `start` outside IDLE is ignored, with no queuing. Changes to `len` after acceptance have no effect.
- Arithmetic: product is 2·DW bits, zero-extended to AW; the sum wraps modulo 2^AW. Operands are unsigned.
- Reset values: state=IDLE, acc=0, `mac_out`=0, `ovf`=0, `busy`=0, `in_ready`=0, `out_valid`=0, counter=0, `len_q`=0.
- Reset mid-job, in any state: next cycle is IDLE with all reset values. The partial result is discarded and no `out_valid` pulse occurs.

## Timing
- `start` accepted at edge t → CLR during cycle t+1 → RUN from cycle t+2; `in_ready` is first high in cycle t+2.
- Last beat accepted at edge u → `out_valid`=1 in cycle u+1, with `mac_out` equal to the final sum.
- Zero-length job: `start` at edge t → `out_valid` in cycle t+1.
- Result taken at edge v (`out_valid` & `out_ready`) → IDLE in cycle v+1. A new `start` can be accepted at edge v+1.
- Minimum job cycle time: len+3 cycles with `in_valid` held high and `out_ready` held high.
- `mac_out` is registered; there is no combinational path from `a`/`b` to `mac_out`. `in_ready` and `out_valid` decode from registered state only.

## Structure
- Shared package `mac_pkg`:
  - state enum: IDLE, CLR, RUN, DONE;
  - default width constants DW_DEF=4, AW_DEF=8, LW_DEF=4.
- One sub-module, `mac_acc`: the multiply-accumulate register.
  - Inputs: `clk`, `rst`, `clr`, `en`, `a`, `b`.
  - Outputs: `acc`, `carry`.
  - The controller drives `clr` in CLR and `en` on accepted beats.
- The beat counter, `len_q`, and the FSM live in `mac_seq_ctrl`.

## Test plan
- Reset: assert `rst` for 5 cycles with random inputs → every output is 0 and `in_ready`=0 throughout.
- Basic job: `len`=3, pairs (1,2), (3,10), (1,2) with `in_valid` always high → `mac_out`=34 (0x22), `ovf`=0, `out_valid` exactly one cycle after the third beat.
- Backpressure:
  - Same job with `in_valid` low for 2 cycles between beats → same result 34, counter unaffected by idle cycles.
  - `out_ready` held low for 4 cycles → `mac_out` and `out_valid` stable throughout.
- Overflow and zero length:
  - `len`=2, pairs (15,15), (15,15) → `mac_out`=194, `ovf`=1.
  - A following job with `len`=0 → `out_valid` in the cycle after `start`, `mac_out`=0, `ovf`=0.
- Ignored start and mid-job reset:
  - `start` pulsed during RUN → no effect on the counter or result.
  - `rst` asserted after the second of four beats → IDLE next cycle, `mac_out`=0, no `out_valid`.
  - A fresh `len`=1 job with (2,3) then yields 6.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the framed multiply-accumulate sequencer.
package mac_pkg;
  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 8;
  localparam int LW_DEF = 4;
endpackage

// File: rtl/mac_acc.sv
// Multiply-accumulate register: unsigned DWxDW product added into an AW-bit wrapping accumulator.
module mac_acc
  import mac_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc,
  output logic          carry
);

  logic [2*DW-1:0] prod;
  logic [AW:0]     sum;

  // One extra bit on top of the accumulator exposes the carry out of the wrap.
  function automatic logic [AW:0] wrap_add(input logic [AW-1:0] x, input logic [2*DW-1:0] p);
    return {1'b0, x} + (AW+1)'(p);
  endfunction

  always_comb begin
    prod  = (2*DW)'(a) * (2*DW)'(b);
    sum   = wrap_add(acc, prod);
    carry = sum[AW];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[AW-1:0];
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer: frames len operand pairs through mac_acc and presents the result under a handshake.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] mac_out,
  output logic          ovf
);

  state_t        state, state_nxt;
  logic [LW-1:0] cnt, len_q;
  logic          clr, en, last, carry;

  assign last = (cnt == len_q - LW'(1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          // A zero-length job skips straight to DONE, clearing on the same edge.
          if (len == '0) begin
            state_nxt = DONE;
            clr       = 1'b1;
          end else begin
            state_nxt = CLR;
          end
        end
      end
      CLR: begin
        clr       = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        en       = in_valid;
        if (in_valid && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q <= len;
        cnt   <= '0;
      end else if (en) begin
        cnt <= cnt + LW'(1);
      end
      if (clr) begin
        ovf <= 1'b0;
      end else if (en) begin
        ovf <= ovf | carry;
      end
    end
  end

  mac_acc #(
    .DW(DW),
    .AW(AW)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .a    (a),
    .b    (b),
    .acc  (mac_out),
    .carry(carry)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed job table, hand-written corner sequences, random jobs.
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [3:0] len, a, b;
  logic       busy, in_ready, out_valid, ovf;
  logic [7:0] mac_out;

  int n_cmp = 0;
  int n_bad = 0;
  int ja[16];
  int jb[16];

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mac_out  (mac_out),
    .ovf      (ovf)
  );

  typedef struct packed {
    logic [4:0]  len;
    logic [15:0] av;
    logic [15:0] bv;
    logic [3:0]  gap;
    logic [3:0]  hold;
    logic        kick;
    logic [7:0]  exp_mac;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE using ja/jb as operands; gap idle cycles between beats,
  // hold cycles of out_ready low in DONE, optional stray start during RUN.
  task automatic run_job(input int L, input int gap, input int hold, input bit kick,
                         input int exp_mac, input int exp_ovf, input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_out_valid"}, out_valid, 0);
    start = 1'b1;
    len   = L[3:0];
    tick();
    start = 1'b0;
    len   = 4'($urandom);
    if (L != 0) begin
      check({tag, ".clr_busy"}, busy, 1);
      check({tag, ".clr_in_ready"}, in_ready, 0);
      check({tag, ".clr_out_valid"}, out_valid, 0);
      tick();
      for (int i = 0; i < L; i++) begin
        if (i > 0) begin
          for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            a = 4'($urandom);
            b = 4'($urandom);
            tick();
          end
        end
        in_valid = 1'b1;
        a = ja[i][3:0];
        b = jb[i][3:0];
        if (kick && i == 1) begin
          start = 1'b1;
          len   = 4'($urandom);
        end
        check({tag, ".run_in_ready"}, in_ready, 1);
        tick();
        start = 1'b0;
        if (i < L - 1) check({tag, ".early_out_valid"}, out_valid, 0);
      end
    end
    // Operands offered while DONE must not be consumed.
    in_valid = 1'b1;
    a = 4'd15;
    b = 4'd15;
    check({tag, ".done_out_valid"}, out_valid, 1);
    check({tag, ".done_in_ready"}, in_ready, 0);
    check({tag, ".mac_out"}, mac_out, exp_mac);
    check({tag, ".ovf"}, ovf, exp_ovf);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ".hold_out_valid"}, out_valid, 1);
      check({tag, ".hold_mac_out"}, mac_out, exp_mac);
      check({tag, ".hold_ovf"}, ovf, exp_ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".after_out_valid"}, out_valid, 0);
    check({tag, ".after_busy"}, busy, 0);
    check({tag, ".after_mac_out"}, mac_out, exp_mac);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int total, L;

    tbl[0] = '{len: 5'd3, av: 16'h0131, bv: 16'h02A2, gap: 4'd0, hold: 4'd0, kick: 1'b0, exp_mac: 8'd34,  exp_ovf: 1'b0};
    tbl[1] = '{len: 5'd3, av: 16'h0131, bv: 16'h02A2, gap: 4'd2, hold: 4'd0, kick: 1'b0, exp_mac: 8'd34,  exp_ovf: 1'b0};
    tbl[2] = '{len: 5'd3, av: 16'h0131, bv: 16'h02A2, gap: 4'd0, hold: 4'd4, kick: 1'b0, exp_mac: 8'd34,  exp_ovf: 1'b0};
    tbl[3] = '{len: 5'd2, av: 16'h00FF, bv: 16'h00FF, gap: 4'd0, hold: 4'd0, kick: 1'b0, exp_mac: 8'd194, exp_ovf: 1'b1};
    tbl[4] = '{len: 5'd0, av: 16'h0000, bv: 16'h0000, gap: 4'd0, hold: 4'd2, kick: 1'b0, exp_mac: 8'd0,   exp_ovf: 1'b0};
    tbl[5] = '{len: 5'd3, av: 16'h0131, bv: 16'h02A2, gap: 4'd1, hold: 4'd1, kick: 1'b1, exp_mac: 8'd34,  exp_ovf: 1'b0};

    // Reset with random inputs toggling.
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      start     = 1'($urandom);
      len       = 4'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a         = 4'($urandom);
      b         = 4'($urandom);
      tick();
      check("rst.busy", busy, 0);
      check("rst.in_ready", in_ready, 0);
      check("rst.out_valid", out_valid, 0);
      check("rst.mac_out", mac_out, 0);
      check("rst.ovf", ovf, 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        ja[i] = int'(tbl[v].av[i*4 +: 4]);
        jb[i] = int'(tbl[v].bv[i*4 +: 4]);
      end
      run_job(int'(tbl[v].len), int'(tbl[v].gap), int'(tbl[v].hold), tbl[v].kick,
              int'(tbl[v].exp_mac), int'(tbl[v].exp_ovf), $sformatf("vec%0d", v));
    end

    // Reset after the second of four beats discards the job.
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 4'd15; b = 4'd15;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", busy, 0);
    check("midrst.in_ready", in_ready, 0);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.mac_out", mac_out, 0);
    check("midrst.ovf", ovf, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midrst.no_out_valid", out_valid, 0);
      check("midrst.idle", busy, 0);
    end
    in_valid = 1'b0;
    ja[0] = 2; jb[0] = 3;
    run_job(1, 0, 0, 1'b0, 6, 0, "fresh");

    // Random jobs against an exact-integer model: wrapped sum and overflow from the true total.
    for (int j = 0; j < 30; j++) begin
      L = int'($urandom_range(0, 15));
      total = 0;
      for (int i = 0; i < L; i++) begin
        ja[i] = int'($urandom_range(0, 15));
        jb[i] = int'($urandom_range(0, 15));
        total += ja[i] * jb[i];
      end
      run_job(L, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom),
              total % 256, (total >= 256) ? 1 : 0, $sformatf("rnd%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
